// File: rtl/sgd_acc_pkg.sv
// Shared constants and types for the SGD gradient accumulator.
// A chunk is LANES signed 32-bit lanes; stage_t carries one beat down the pipeline.
package sgd_acc_pkg;

  localparam int LANES       = 8;
  localparam int DEPTH_BITS  = 9;
  localparam int CHUNK_SHIFT = 8;
  localparam int CHUNK_W     = LANES * 32;

  typedef logic signed [31:0] lane_t;
  typedef lane_t chunk_t [LANES];

  typedef struct {
    logic                  valid;
    logic                  first;
    logic                  last;
    logic [DEPTH_BITS-1:0] addr;
    chunk_t                data;
  } stage_t;

  function automatic logic [CHUNK_W-1:0] pack_chunk(input chunk_t c);
    logic [CHUNK_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*32 +: 32] = c[i];
    return v;
  endfunction

endpackage

// File: rtl/sgd_acc_buffer.sv
// Per-chunk partial-sum store: simple dual-port RAM with a registered read.
// Read-before-write on an address collision; the top covers that case by forwarding.
module sgd_acc_buffer
  import sgd_acc_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [DEPTH_BITS-1:0] i_wr_addr,
  input  logic [CHUNK_W-1:0]    i_wr_data,
  input  logic [DEPTH_BITS-1:0] i_rd_addr,
  output logic [CHUNK_W-1:0]    o_rd_data
);

  logic [CHUNK_W-1:0] r_mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/sgd_gradient_accumulator.sv
// Sums per-sample gradient chunks lane-wise over a mini-batch and streams the
// batch totals out in chunk order on the last sample (3-cycle beat-to-output latency).
module sgd_gradient_accumulator
  import sgd_acc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               started,
  input  logic [31:0]        dimension,
  input  logic [31:0]        batch_size,
  input  logic [CHUNK_W-1:0] grad_in,
  input  logic               grad_in_valid,
  output lane_t              acc_gradient [LANES],
  output logic               acc_gradient_valid [LANES]
);

  logic [31:0] r_n_chunks;
  logic [31:0] r_n_m1;
  logic [31:0] r_chunk_cnt;
  logic [31:0] r_sample_cnt;
  logic [31:0] w_bs_m1;

  stage_t r_s0;
  stage_t r_s1;

  // Write-back history: [0] S2 result, [1] driving the RAM write port,
  // [2] written last edge (missed by the read that launched on that same edge).
  logic                  r_wv [3];
  logic [DEPTH_BITS-1:0] r_wa [3];
  chunk_t                r_wd [3];

  logic                  r_out_valid;
  chunk_t                r_out_data;

  logic [CHUNK_W-1:0]    w_rd_data;
  chunk_t                w_rd_chunk;
  chunk_t                w_prev;
  chunk_t                w_sum;

  assign w_bs_m1 = (batch_size == 32'd0) ? 32'd0 : batch_size - 32'd1;

  sgd_acc_buffer u_buffer (
    .clk       (clk),
    .i_wr_en   (r_wv[1]),
    .i_wr_addr (r_wa[1]),
    .i_wr_data (pack_chunk(r_wd[1])),
    .i_rd_addr (r_s0.addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    for (int i = 0; i < LANES; i++) w_rd_chunk[i] = w_rd_data[i*32 +: 32];
  end

  // Oldest match first so the youngest matching write wins.
  always_comb begin
    w_prev = w_rd_chunk;
    for (int k = 2; k >= 0; k--) begin
      if (r_wv[k] && (r_wa[k] == r_s1.addr)) w_prev = r_wd[k];
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++)
      w_sum[i] = r_s1.first ? r_s1.data[i] : w_prev[i] + r_s1.data[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_chunks   <= '0;
      r_n_m1       <= '0;
      r_chunk_cnt  <= '0;
      r_sample_cnt <= '0;
    end else begin
      r_n_chunks <= {{CHUNK_SHIFT{1'b0}}, dimension[31:CHUNK_SHIFT]}
                  + {31'd0, |dimension[CHUNK_SHIFT-1:0]};
      r_n_m1     <= r_n_chunks - 32'd1;
      if (!started) begin
        r_chunk_cnt  <= '0;
        r_sample_cnt <= '0;
      end else if (grad_in_valid) begin
        if (r_chunk_cnt == r_n_m1) begin
          r_chunk_cnt  <= '0;
          r_sample_cnt <= (r_sample_cnt == w_bs_m1) ? 32'd0 : r_sample_cnt + 32'd1;
        end else begin
          r_chunk_cnt <= r_chunk_cnt + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0.valid <= 1'b0;
      r_s0.first <= 1'b0;
      r_s0.last  <= 1'b0;
      r_s0.addr  <= '0;
      r_s1.valid <= 1'b0;
      r_s1.first <= 1'b0;
      r_s1.last  <= 1'b0;
      r_s1.addr  <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s0.data[i] <= '0;
        r_s1.data[i] <= '0;
      end
    end else begin
      r_s0.valid <= started & grad_in_valid;
      r_s0.first <= (r_sample_cnt == 32'd0);
      r_s0.last  <= (r_sample_cnt == w_bs_m1);
      r_s0.addr  <= r_chunk_cnt[DEPTH_BITS-1:0];
      for (int i = 0; i < LANES; i++) r_s0.data[i] <= grad_in[i*32 +: 32];
      r_s1 <= r_s0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        r_wv[k] <= 1'b0;
        r_wa[k] <= '0;
        for (int i = 0; i < LANES; i++) r_wd[k][i] <= '0;
      end
      r_out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) r_out_data[i] <= '0;
    end else begin
      r_wv[0] <= r_s1.valid & ~r_s1.last;
      r_wa[0] <= r_s1.addr;
      r_wd[0] <= w_sum;
      for (int k = 1; k < 3; k++) begin
        r_wv[k] <= r_wv[k-1];
        r_wa[k] <= r_wa[k-1];
        r_wd[k] <= r_wd[k-1];
      end
      r_out_valid <= r_s1.valid & r_s1.last;
      if (r_s1.valid && r_s1.last) r_out_data <= w_sum;
    end
  end

  assign acc_gradient = r_out_data;

  always_comb begin
    for (int i = 0; i < LANES; i++) acc_gradient_valid[i] = r_out_valid;
  end

endmodule

// File: tb/tb_sgd_gradient_accumulator.sv
// Directed bench for sgd_gradient_accumulator: stimulus pushes expected batch
// totals and due cycles into a scoreboard; a negedge monitor pops and compares.
module tb_sgd_gradient_accumulator;
  import sgd_acc_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               started = 1'b0;
  logic [31:0]        dimension = '0;
  logic [31:0]        batch_size = '0;
  logic [CHUNK_W-1:0] grad_in = '0;
  logic               grad_in_valid = 1'b0;
  lane_t              acc_gradient [LANES];
  logic               acc_gradient_valid [LANES];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [CHUNK_W-1:0] q[$];
  int                 dq[$];

  sgd_gradient_accumulator dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .started            (started),
    .dimension          (dimension),
    .batch_size         (batch_size),
    .grad_in            (grad_in),
    .grad_in_valid      (grad_in_valid),
    .acc_gradient       (acc_gradient),
    .acc_gradient_valid (acc_gradient_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CHUNK_W-1:0] splat(input logic [31:0] v);
    logic [CHUNK_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [CHUNK_W-1:0] scaled(input int v);
    logic [CHUNK_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = 32'(v * (i + 1));
    return r;
  endfunction

  function automatic logic [CHUNK_W-1:0] got_chunk();
    logic [CHUNK_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = acc_gradient[i];
    return r;
  endfunction

  always @(negedge clk) begin
    logic [CHUNK_W-1:0] e;
    int  d;
    bit  any_v;
    bit  all_v;
    any_v = 1'b0;
    all_v = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      any_v = any_v | acc_gradient_valid[i];
      all_v = all_v & acc_gradient_valid[i];
    end
    if (any_v) begin
      total++;
      if (!all_v) begin
        bad++;
        $display("FAIL valid_lanes: lanes disagree at cycle %0d, required all high", cyc);
      end
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got %h at cycle %0d, required no output", got_chunk(), cyc);
      end else begin
        e = q.pop_front();
        d = dq.pop_front();
        if (got_chunk() !== e) begin
          bad++;
          $display("FAIL out_data: got %h required %h", got_chunk(), e);
        end
        total++;
        if (cyc != d) begin
          bad++;
          $display("FAIL out_latency: got cycle %0d required cycle %0d", cyc, d);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input logic [31:0] dim, input logic [31:0] bs);
    started = 1'b0;
    idle(1);
    dimension  = dim;
    batch_size = bs;
    started    = 1'b1;
    idle(2);
  endtask

  task automatic beat(input logic [CHUNK_W-1:0] d, input bit push, input logic [CHUNK_W-1:0] e);
    grad_in       = d;
    grad_in_valid = 1'b1;
    @(posedge clk);
    #1;
    grad_in_valid = 1'b0;
    if (push) begin
      q.push_back(e);
      dq.push_back(cyc + 2);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", q.size());
      q.delete();
      dq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CHUNK_W-1:0] d;
    logic [CHUNK_W-1:0] e;
    logic [CHUNK_W-1:0] e2;

    #12;
    total++;
    if (acc_gradient_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b required 0", acc_gradient_valid[0]);
    end
    total++;
    if (got_chunk() !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h required 0", got_chunk());
    end
    #10 rst_n = 1'b1;

    // N=2, batch 1: pass-through
    start_job(32'd512, 32'd1);
    d = '0; d[31:0] = 32'd5;
    beat(d, 1'b1, d);
    d = '0; d[31:0] = -32'sd7;
    beat(d, 1'b1, d);
    drain();

    // N=4, batch 3: RAM read path
    start_job(32'd1024, 32'd3);
    for (int s = 1; s <= 3; s++)
      for (int ch = 0; ch < 4; ch++)
        beat(splat(32'(s)), s == 3, splat(32'd6));
    drain();

    // N=1, batch 4: forwarding at distance 1
    start_job(32'd256, 32'd4);
    beat(scaled(10), 1'b0, '0);
    beat(scaled(20), 1'b0, '0);
    beat(scaled(30), 1'b0, '0);
    beat(scaled(40), 1'b1, scaled(100));
    drain();

    // N=2 (partial chunk), batch 2: wrap and distance-2 forwarding
    start_job(32'd300, 32'd2);
    d = splat(32'd3); d[255:224] = 32'h7FFF_FFFF;
    beat(d, 1'b0, '0);
    beat(splat(32'd5), 1'b0, '0);
    d = splat(32'd4); d[255:224] = 32'd1;
    e = splat(32'd7); e[255:224] = 32'h8000_0000;
    beat(d, 1'b1, e);
    beat(splat(-32'sd2), 1'b1, splat(32'd3));
    drain();

    // N=3, batch 2: distance-3 forwarding
    start_job(32'd768, 32'd2);
    for (int k = 1; k <= 3; k++) beat(scaled(k), 1'b0, '0);
    for (int k = 1; k <= 3; k++) beat(scaled(10 * k), 1'b1, scaled(11 * k));
    drain();

    // Abort mid-sample, then two full samples with gaps
    start_job(32'd1024, 32'd2);
    beat(splat(32'd100), 1'b0, '0);
    beat(splat(32'd100), 1'b0, '0);
    start_job(32'd1024, 32'd2);
    for (int ch = 0; ch < 4; ch++) beat(splat(32'd3), 1'b0, '0);
    idle(1);
    for (int ch = 0; ch < 4; ch++) begin
      beat(splat(32'd3), 1'b1, splat(32'd6));
      if (ch == 1) idle(2);
    end
    drain();

    // Async reset while an output is being presented
    start_job(32'd256, 32'd1);
    e2 = '0; e2[31:0] = 32'd9;
    beat(e2, 1'b1, e2);
    idle(2);
    @(negedge clk);
    #1;
    total++;
    if (acc_gradient_valid[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %b required 1", acc_gradient_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (acc_gradient_valid[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_valid: got %b required 0", acc_gradient_valid[0]);
    end
    total++;
    if (acc_gradient[0] !== 32'sd0) begin
      bad++;
      $display("FAIL async_reset_data: got %0d required 0", acc_gradient[0]);
    end
    started = 1'b0;
    #12;
    rst_n = 1'b1;
    idle(1);
    start_job(32'd256, 32'd2);
    beat(splat(32'd1), 1'b0, '0);
    beat(splat(32'd1), 1'b1, splat(32'd2));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
